muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit sitting between the register-file read ports and the register-file write port. It takes rs1/rs2 operand values and a destination index, computes over several cycles with a start/done handshake, then presents a one-cycle result plus write enable that drive the register file's WD3/A3/WE3 inputs. The unit holds the pipeline busy while it runs.

## Interface
- Parameters: none (width fixed at 32, iteration count fixed at 32).
- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- flush  in  1  abort in-flight operation.
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  32  rs1 value (RD1).
- op_b  in  32  rs2 value (RD2).
- rd_in  in  5  destination register index.
- busy  out  1  operation accepted and not yet completed.
- done  out  1  one-cycle completion pulse.
- we  out  1  register-file write enable; equals done.
- rd_out  out  5  latched rd_in; drives register-file write address.
- result  out  32  computed value; valid when done=1.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 and flush=0 → latch funct3, rd_in, operand magnitudes and sign flags; go CALC (counter=0), busy=1.
- CALC: one iteration per cycle; multiply = shift-add on 64-bit accumulator; divide = restoring, one quotient bit per cycle. After counter reaches 31 → FIX.
- FIX: apply sign correction (negate product/quotient/remainder per RV32M rules); select low word (MUL), high word (MULH/MULHSU/MULHU), quotient or remainder → DONE.
- DONE: done=we=1, result and rd_out valid one cycle; → IDLE, busy=0.
- Signedness: MULH both signed; MULHSU op_a signed, op_b unsigned; MULHU/DIVU/REMU unsigned.
- Divide by zero: quotient 0xFFFFFFFF, remainder = op_a (signed and unsigned).
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- start while busy=1: ignored, no effect on running op.
- flush=1 in any state: next state IDLE, busy=0, done/we never pulse for the aborted op. flush and start together in IDLE: flush wins, start dropped.
- rd_in=0 computes normally and pulses we; register file discards x0 writes.
- Reset: state IDLE, busy=0, done=0, we=0, result=0, rd_out=0, counter=0.

## Timing
- start sampled at edge N → busy=1 from cycle N+1; CALC cycles N+1..N+32; FIX N+33; done/we=1 in cycle N+34 only.
- busy drops together with done falling (cycle N+35 busy=0); new start accepted in cycle N+35.
- result and rd_out hold their last values after done until next DONE or reset.
- Reset mid-operation: outputs at reset values in the cycle after the reset edge; no done for the aborted op.

## Configuration
- MULDIV_FAST_SPECIAL_EN defined: divide-by-zero and signed-overflow divides bypass CALC/FIX; IDLE → DONE directly, done in cycle N+1.
- Undefined: special cases take the full 34-cycle path; results identical, only latency differs.

## Structure
- Package muldiv_pkg: funct3 op constants, state enum, XLEN=32, ITER=32.
- One natural sub-module: muldiv_datapath (accumulator/remainder registers, shift-add/subtract step, sign fix); top holds FSM, counter, handshake.

## Test plan
- MUL op_a=7, op_b=0xFFFFFFFD, rd_in=5, start at N → done/we at N+34, result 0xFFFFFFEB, rd_out 5; busy high N+1..N+34.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0; DIV 0xFFFFFFF9(−7)/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF.
- DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5; done at N+1 with MULDIV_FAST_SPECIAL_EN, N+34 without.
- Second start at N+5 while busy → ignored, only first result delivered; flush at N+10 → busy=0 at N+11, no done, new start at N+11 completes at N+45.
- reset at N+20 mid-divide → busy=done=we=0, result=0, rd_out=0 at N+21; next op completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants, FSM state type and divide special-case helper for muldiv_unit.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] val;
  } special_t;

  // Divide-by-zero and signed-overflow results, as defined by RV32M.
  function automatic special_t special_div(input logic [2:0] f3,
                                           input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
    special_t s;
    s = '0;
    if (f3[2]) begin
      if (b == '0) begin
        s.hit = 1'b1;
        s.val = f3[1] ? a : '1;
      end else if (!f3[0] && (a == 32'h8000_0000) && (b == '1)) begin
        s.hit = 1'b1;
        s.val = f3[1] ? '0 : 32'h8000_0000;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline and muldiv_unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic            we;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, op_a, op_b, rd_in,
    input  busy, done, we, rd_out, result
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b, rd_in,
    output busy, done, we, rd_out, result
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Magnitude shift-add multiplier / restoring divider sharing one 64-bit hi:lo pair,
// with RV32M sign correction applied combinationally on the final registers.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic [XLEN-1:0] o_fixed
);

  logic [XLEN-1:0]   r_hi, r_lo, r_b;
  logic [2:0]        r_op;
  logic              r_neg_q, r_neg_r;

  logic              w_a_sgn, w_b_sgn, w_sa, w_sb, w_is_div, w_ge;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_sub, w_quo, w_rem;
  logic [XLEN:0]     w_sum, w_shift;
  logic [2*XLEN-1:0] w_prod, w_prod_s;

  always_comb begin
    w_a_sgn  = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
               (i_funct3 == F3_DIV)  || (i_funct3 == F3_REM);
    w_b_sgn  = (i_funct3 == F3_MULH) || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
    w_sa     = w_a_sgn & i_op_a[XLEN-1];
    w_sb     = w_b_sgn & i_op_b[XLEN-1];
    w_mag_a  = w_sa ? -i_op_a : i_op_a;
    w_mag_b  = w_sb ? -i_op_b : i_op_b;
    w_is_div = i_funct3[2];
    // Multiply: r_lo holds the multiplier, r_b the multiplicand.
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    w_shift  = {r_hi, r_lo[XLEN-1]};
    w_ge     = (w_shift >= {1'b0, r_b});
    w_sub    = w_shift[XLEN-1:0] - r_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_load) begin
      r_op    <= i_funct3;
      r_hi    <= '0;
      r_lo    <= w_is_div ? w_mag_a : w_mag_b;
      r_b     <= w_is_div ? w_mag_b : w_mag_a;
      // Divide-by-zero quotient stays all-ones regardless of the dividend sign.
      r_neg_q <= (w_sa ^ w_sb) & ~(w_is_div & (i_op_b == '0));
      r_neg_r <= w_sa;
    end else if (i_step) begin
      if (r_op[2]) begin
        r_hi <= w_ge ? w_sub : w_shift[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_ge};
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_quo    = r_neg_q ? -r_lo : r_lo;
    w_rem    = r_neg_r ? -r_hi : r_hi;
    case (r_op)
      F3_MUL:                       o_fixed = w_prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: o_fixed = w_prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              o_fixed = w_quo;
      default:                      o_fixed = w_rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter and register-file handshake.
// Optional MULDIV_FAST_SPECIAL_EN: divide-by-zero / signed overflow complete straight from IDLE.
module muldiv_unit
  import muldiv_pkg::*;
(
  input logic     CLK,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_result, w_fixed, w_fast_val;
  logic [4:0]       r_rd, r_rd_out;
  logic             w_accept, w_fast_hit;

`ifdef MULDIV_FAST_SPECIAL_EN
  special_t w_spec;
  always_comb begin
    w_spec     = special_div(bus.funct3, bus.op_a, bus.op_b);
    w_fast_hit = w_spec.hit;
    w_fast_val = w_spec.val;
  end
`else
  always_comb begin
    w_fast_hit = 1'b0;
    w_fast_val = '0;
  end
`endif

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    bus.busy = (r_state != ST_IDLE);
    bus.done = (r_state == ST_DONE);
    bus.we   = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE: if (bus.start && !bus.flush) begin
        w_accept = 1'b1;
        w_next   = w_fast_hit ? ST_DONE : ST_CALC;
      end
      ST_CALC: if (r_cnt == LAST_ITER) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (bus.flush) w_next = ST_IDLE;
  end

  // rd_out/result only move at completion, so an aborted op leaves them untouched.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_rd     <= '0;
      r_rd_out <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt <= '0;
        r_rd  <= bus.rd_in;
      end else if (r_state == ST_CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept && w_fast_hit) begin
        r_result <= w_fast_val;
        r_rd_out <= bus.rd_in;
      end else if ((r_state == ST_FIX) && !bus.flush) begin
        r_result <= w_fixed;
        r_rd_out <= r_rd;
      end
    end
  end

  assign bus.result = r_result;
  assign bus.rd_out = r_rd_out;

  muldiv_datapath u_datapath (
    .clk      (CLK),
    .rst      (reset),
    .i_load   (w_accept),
    .i_step   (r_state == ST_CALC),
    .i_funct3 (bus.funct3),
    .i_op_a   (bus.op_a),
    .i_op_b   (bus.op_b),
    .o_fixed  (w_fixed)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; latency of special divides follows MULDIV_FAST_SPECIAL_EN.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  muldiv_if u_if ();
  muldiv_unit dut (.CLK(CLK), .reset(reset), .bus(u_if));

  int n_assert = 0;
  int n_fail   = 0;

`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 34;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a request in cycle N; returns at the sampling point of cycle N+1.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge CLK);
    u_if.funct3 = f3;
    u_if.op_a   = a;
    u_if.op_b   = b;
    u_if.rd_in  = rd;
    u_if.start  = 1'b1;
    @(negedge CLK);
    u_if.start  = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output bit busy_ok);
    lat     = lat0;
    busy_ok = 1'b1;
    while (u_if.done !== 1'b1 && lat < 100) begin
      if (u_if.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge CLK);
      lat++;
    end
    if (u_if.busy !== 1'b1) busy_ok = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat);
    int lat;
    bit bok;
    issue(f3, a, b, rd);
    wait_done(1, lat, bok);
    chk({tag, "_lat"}, lat, exp_lat);
    chk(tag, u_if.result, exp);
    chk({tag, "_rd"}, {27'd0, u_if.rd_out}, {27'd0, rd});
    chk({tag, "_we"}, {31'd0, u_if.we}, 32'd1);
  endtask

  initial begin
    int lat;
    bit bok;
    int n_done;

    reset       = 1'b1;
    u_if.start  = 1'b0;
    u_if.flush  = 1'b0;
    u_if.funct3 = '0;
    u_if.op_a   = '0;
    u_if.op_b   = '0;
    u_if.rd_in  = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy",   {31'd0, u_if.busy}, 32'd0);
    chk("rst_done",   {31'd0, u_if.done}, 32'd0);
    chk("rst_we",     {31'd0, u_if.we},   32'd0);
    chk("rst_result", u_if.result,        32'd0);
    chk("rst_rd",     {27'd0, u_if.rd_out}, 32'd0);
    reset = 1'b0;

    // MUL with full timing check
    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
    chk("mul_busy_n1", {31'd0, u_if.busy}, 32'd1);
    wait_done(1, lat, bok);
    chk("mul_lat",     lat, 32'd34);
    chk("mul_busy_hi", {31'd0, bok}, 32'd1);
    chk("mul",         u_if.result, 32'hFFFF_FFEB);
    chk("mul_rd",      {27'd0, u_if.rd_out}, 32'd5);
    chk("mul_we",      {31'd0, u_if.we}, 32'd1);
    @(negedge CLK);
    chk("mul_busy_n35", {31'd0, u_if.busy}, 32'd0);
    chk("mul_done_n35", {31'd0, u_if.done}, 32'd0);
    chk("mul_we_n35",   {31'd0, u_if.we},   32'd0);
    chk("mul_hold",     u_if.result, 32'hFFFF_FFEB);
    chk("mul_rd_hold",  {27'd0, u_if.rd_out}, 32'd5);

    do_op("mulhu",   F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 34);
    do_op("mulh",    F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 34);
    do_op("mulhsu",  F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 34);
    do_op("div_ovf", F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd4,  32'h8000_0000, SPEC_LAT);
    do_op("rem_ovf", F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, SPEC_LAT);
    do_op("div_neg", F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 34);
    do_op("rem_neg", F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 34);
    do_op("divu_z",  F3_DIVU,   32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, SPEC_LAT);
    do_op("remu_z",  F3_REMU,   32'd5,         32'd0,         5'd10, 32'd5,         SPEC_LAT);
    do_op("div_z",   F3_DIV,    32'hFFFF_FFF9, 32'd0,         5'd11, 32'hFFFF_FFFF, SPEC_LAT);
    do_op("rem_z",   F3_REM,    32'hFFFF_FFF9, 32'd0,         5'd0,  32'hFFFF_FFF9, SPEC_LAT);
    do_op("divu",    F3_DIVU,   32'd100,       32'd7,         5'd13, 32'd14,        34);

    // Second start while busy is ignored
    issue(F3_MUL, 32'd3, 32'd4, 5'd7);
    repeat (4) @(negedge CLK);
    u_if.op_a  = 32'd9;
    u_if.op_b  = 32'd9;
    u_if.rd_in = 5'd9;
    u_if.start = 1'b1;
    @(negedge CLK);
    u_if.start = 1'b0;
    wait_done(6, lat, bok);
    chk("ign_lat", lat, 32'd34);
    chk("ign",     u_if.result, 32'd12);
    chk("ign_rd",  {27'd0, u_if.rd_out}, 32'd7);
    n_done = 0;
    repeat (40) begin
      @(negedge CLK);
      if (u_if.done === 1'b1) n_done++;
    end
    chk("ign_extra_done", n_done, 32'd0);
    chk("ign_idle", {31'd0, u_if.busy}, 32'd0);

    // Flush mid-operation, then a fresh start right after
    issue(F3_DIVU, 32'd1000, 32'd7, 5'd3);
    repeat (9) @(negedge CLK);
    u_if.flush = 1'b1;
    chk("fl_busy_n10", {31'd0, u_if.busy}, 32'd1);
    @(negedge CLK);
    u_if.flush = 1'b0;
    chk("fl_busy_n11", {31'd0, u_if.busy}, 32'd0);
    chk("fl_done_n11", {31'd0, u_if.done}, 32'd0);
    chk("fl_hold",     u_if.result, 32'd12);
    u_if.funct3 = F3_MULHU;
    u_if.op_a   = 32'hFFFF_FFFF;
    u_if.op_b   = 32'd2;
    u_if.rd_in  = 5'd12;
    u_if.start  = 1'b1;
    @(negedge CLK);
    u_if.start = 1'b0;
    wait_done(1, lat, bok);
    chk("fl_new_lat", lat, 32'd34);
    chk("fl_new",     u_if.result, 32'd1);
    chk("fl_new_rd",  {27'd0, u_if.rd_out}, 32'd12);

    // Reset mid-divide
    issue(F3_DIV, 32'd1000, 32'd3, 5'd20);
    repeat (19) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk("mrst_busy",   {31'd0, u_if.busy}, 32'd0);
    chk("mrst_done",   {31'd0, u_if.done}, 32'd0);
    chk("mrst_we",     {31'd0, u_if.we},   32'd0);
    chk("mrst_result", u_if.result,        32'd0);
    chk("mrst_rd",     {27'd0, u_if.rd_out}, 32'd0);
    do_op("post_rst", F3_DIV, 32'd1000, 32'd3, 5'd20, 32'd333, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
